// File: rtl/pixel_palette_if.sv
// -----------------------------------------------------------------------------
// pixel_palette_if
// Bundle of pixel-path and palette-write signals for pixel_palette.
//   master : pixel source / CPU side. It drives the pixel attributes and the
//            palette write port, and it receives the colour outputs.
//   slave  : the palette block itself.
// Signals:
//   de_in, pix_on, fg_idx, bg_idx, blink_attr, frame_tick  pixel stream inputs
//   wr_en, wr_addr, wr_data                                palette write port
//   R, G, B, de_out                                        registered outputs
// -----------------------------------------------------------------------------
interface pixel_palette_if #(
   parameter int COLOR_W = 8,
   parameter int IDX_W   = 2
);
   logic                   de_in;
   logic                   pix_on;
   logic [IDX_W-1:0]       fg_idx;
   logic [IDX_W-1:0]       bg_idx;
   logic                   blink_attr;
   logic                   frame_tick;
   logic                   wr_en;
   logic [IDX_W-1:0]       wr_addr;
   logic [3*COLOR_W-1:0]   wr_data;
   logic [COLOR_W-1:0]     R;
   logic [COLOR_W-1:0]     G;
   logic [COLOR_W-1:0]     B;
   logic                   de_out;

   modport master (
      output de_in, pix_on, fg_idx, bg_idx, blink_attr, frame_tick,
      output wr_en, wr_addr, wr_data,
      input  R, G, B, de_out
   );

   modport slave (
      input  de_in, pix_on, fg_idx, bg_idx, blink_attr, frame_tick,
      input  wr_en, wr_addr, wr_data,
      output R, G, B, de_out
   );
endinterface

// File: rtl/pixel_palette.sv
// -----------------------------------------------------------------------------
// pixel_palette
// Two-stage registered colour generator for the text-mode video path. It takes
// a character-ROM pixel bit and per-character fg/bg palette indices and
// produces R/G/B from a writable palette register file.
//
// Ports:
//   clk    pixel clock, rising edge
//   rst_n  asynchronous active-low reset
//   pif    pixel_palette_if.slave. It carries the pixel stream inputs, the
//          palette write port, and the registered R/G/B/de_out outputs.
//
// Optional feature: define PALETTE_BLINK_EN to build the frame blink counter.
// When the feature is enabled, a glyph pixel with blink_attr set shows its
// background colour during the "hidden" blink phase. When the feature is not
// built, blink_attr and frame_tick are ignored.
//
// Latency is 2 clk from the inputs to R/G/B/de_out. The block accepts one pixel
// per clock.
// -----------------------------------------------------------------------------
module pixel_palette #(
   parameter int COLOR_W      = 8,
   parameter int N_COLORS     = 4,
   parameter int IDX_W        = 2,
   parameter int BLINK_FRAMES = 30
) (
   input logic             clk,
   input logic             rst_n,
   pixel_palette_if.slave  pif
);

   localparam int RGB_W  = 3 * COLOR_W;
   localparam int STAGES = 2;

   localparam logic [RGB_W-1:0] YELLOW = {{COLOR_W{1'b1}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}};
   localparam logic [RGB_W-1:0] BLACK  = '0;
   localparam logic [RGB_W-1:0] RED    = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};

   // Default palette contents: entry 0 is yellow, entry 1 is black, and every
   // other entry is red.
   function automatic logic [RGB_W-1:0] reset_color(input int i);
      if (i == 0)      return YELLOW;
      else if (i == 1) return BLACK;
      else             return RED;
   endfunction

   // ---------------------------------------------------------------------------
   // Palette register file
   // The write decode compares against each implemented entry. An address at or
   // above N_COLORS matches no entry, so that write drops out.
   // ---------------------------------------------------------------------------
   logic [RGB_W-1:0] pal [N_COLORS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_COLORS; i++) pal[i] <= reset_color(i);
      end else if (pif.wr_en) begin
         for (int i = 0; i < N_COLORS; i++)
            if (pif.wr_addr == IDX_W'(i)) pal[i] <= pif.wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Blink phase
   // ---------------------------------------------------------------------------
   logic hide;

`ifdef PALETTE_BLINK_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] blink_cnt;
   logic             blink_phase;

   // blink_phase flips on the same edge that samples the last tick of a
   // half-period. Stage 1 sees the new phase from the following edge onward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (pif.frame_tick) begin
         if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt   <= blink_cnt + CNT_W'(1);
         end
      end
   end

   assign hide = pif.pix_on & pif.blink_attr & blink_phase;
`else
   logic unused_blink;
   assign unused_blink = &{1'b0, pif.blink_attr, pif.frame_tick};
   assign hide         = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Stage 1: choose the palette index and start the valid pipe
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0]  sel_nxt;
   logic [IDX_W-1:0]  sel_q;
   logic [STAGES:1]   vld_pipe;

   assign sel_nxt = (pif.pix_on && !hide) ? pif.fg_idx : pif.bg_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q    <= '0;
         vld_pipe <= '0;
      end else begin
         sel_q    <= sel_nxt;
         vld_pipe <= {vld_pipe[STAGES-1:1], pif.de_in};
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: palette lookup and output register
   // The lookup reads the palette flops before this edge's write. A colliding
   // write therefore shows up one pixel later, and the current output does not
   // glitch. An index with no matching entry falls through to the error colour.
   // ---------------------------------------------------------------------------
   logic [RGB_W-1:0] lut_rgb;
   logic [RGB_W-1:0] rgb_q;

   always_comb begin
      lut_rgb = RED;
      for (int i = 0; i < N_COLORS; i++)
         if (sel_q == IDX_W'(i)) lut_rgb = pal[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb_q <= '0;
      else        rgb_q <= vld_pipe[1] ? lut_rgb : BLACK;
   end

   assign pif.R      = rgb_q[RGB_W-1 -: COLOR_W];
   assign pif.G      = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign pif.B      = rgb_q[COLOR_W-1:0];
   assign pif.de_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_pixel_palette.sv
// -----------------------------------------------------------------------------
// tb_pixel_palette
// Directed bench for pixel_palette. It drives two instances from the same
// stimulus: a 4-entry palette and a 3-entry palette (index 3 is out of range in
// the second one). Both instances use BLINK_FRAMES=2. Each observed value is
// packed as {de_out, R, G, B}.
// -----------------------------------------------------------------------------
module tb_pixel_palette;

   localparam logic [24:0] O_YEL  = {1'b1, 24'hFFFF00};
   localparam logic [24:0] O_BLK  = {1'b1, 24'h000000};
   localparam logic [24:0] O_RED  = {1'b1, 24'hFF0000};
   localparam logic [24:0] O_OFF  = 25'h0;
`ifdef PALETTE_BLINK_EN
   localparam logic [24:0] O_BLNK = O_YEL;   // a hidden glyph shows bg = yellow
`else
   localparam logic [24:0] O_BLNK = O_BLK;   // no blink: the glyph stays black
`endif

   logic        clk, rst_n;
   logic        de_in, pix_on, blink_attr, frame_tick, wr_en;
   logic [1:0]  fg_idx, bg_idx, wr_addr;
   logic [23:0] wr_data;

   int n_chk  = 0;
   int n_pass = 0;

   pixel_palette_if #(.COLOR_W(8), .IDX_W(2)) pif4 ();
   pixel_palette_if #(.COLOR_W(8), .IDX_W(2)) pif3 ();

   assign pif4.de_in = de_in;   assign pif3.de_in = de_in;
   assign pif4.pix_on = pix_on; assign pif3.pix_on = pix_on;
   assign pif4.fg_idx = fg_idx; assign pif3.fg_idx = fg_idx;
   assign pif4.bg_idx = bg_idx; assign pif3.bg_idx = bg_idx;
   assign pif4.blink_attr = blink_attr; assign pif3.blink_attr = blink_attr;
   assign pif4.frame_tick = frame_tick; assign pif3.frame_tick = frame_tick;
   assign pif4.wr_en = wr_en;     assign pif3.wr_en = wr_en;
   assign pif4.wr_addr = wr_addr; assign pif3.wr_addr = wr_addr;
   assign pif4.wr_data = wr_data; assign pif3.wr_data = wr_data;

   pixel_palette #(.COLOR_W(8), .N_COLORS(4), .IDX_W(2), .BLINK_FRAMES(2))
      u_dut4 (.clk(clk), .rst_n(rst_n), .pif(pif4.slave));
   pixel_palette #(.COLOR_W(8), .N_COLORS(3), .IDX_W(2), .BLINK_FRAMES(2))
      u_dut3 (.clk(clk), .rst_n(rst_n), .pif(pif3.slave));

   wire [24:0] o4 = {pif4.de_out, pif4.R, pif4.G, pif4.B};
   wire [24:0] o3 = {pif3.de_out, pif3.R, pif3.G, pif3.B};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step2();
      step();
      step();
   endtask

   task automatic pix(input logic de, input logic on, input logic [1:0] fg,
                      input logic [1:0] bg, input logic blk);
      de_in = de; pix_on = on; fg_idx = fg; bg_idx = bg; blink_attr = blk;
   endtask

   task automatic wr(input logic [1:0] a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   // One frame_tick pulse, then let the new phase reach the outputs.
   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step2();
   endtask

   initial begin
      rst_n = 1'b0;
      pix(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
      frame_tick = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      step2();
      chk("reset_out4", o4, O_OFF);
      chk("reset_out3", o3, O_OFF);
      rst_n = 1'b1;

      // Default palette contents
      pix(1'b1, 1'b0, 2'd1, 2'd0, 1'b0); step2();
      chk("dflt_bg0_yellow", o4, O_YEL);
      pix(1'b1, 1'b1, 2'd1, 2'd0, 1'b0); step2();
      chk("dflt_fg1_black", o4, O_BLK);
      pix(1'b1, 1'b1, 2'd2, 2'd0, 1'b0); step2();
      chk("dflt_fg2_red", o4, O_RED);
      pix(1'b0, 1'b1, 2'd0, 2'd0, 1'b0); step2();
      chk("de_off_black", o4, O_OFF);

      // Write entry 2, then select it as the foreground
      wr(2'd2, 24'h1234AB);
      pix(1'b1, 1'b1, 2'd2, 2'd0, 1'b0); step2();
      chk("wr2_dut4", o4, {1'b1, 24'h1234AB});
      chk("wr2_dut3", o3, {1'b1, 24'h1234AB});

      // Entry 3 is in stage 1 while the write to entry 3 lands
      pix(1'b1, 1'b1, 2'd3, 2'd0, 1'b0); step();
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 24'hABCDEF;
      step();
      wr_en = 1'b0;
      chk("coll_old_red", o4, O_RED);
      chk("oor_dut3_a", o3, O_RED);
      step();
      chk("coll_new_val", o4, {1'b1, 24'hABCDEF});
      chk("oor_dut3_wr_ignored", o3, O_RED);

      // Blink: fg=1 black, bg=0 yellow
      pix(1'b1, 1'b1, 2'd1, 2'd0, 1'b1); step2();
      chk("blink_t0", o4, O_BLK);
      tick(); chk("blink_t1", o4, O_BLK);
      tick(); chk("blink_t2", o4, O_BLNK);
      tick(); chk("blink_t3", o4, O_BLNK);
      tick(); chk("blink_t4", o4, O_BLK);
      pix(1'b1, 1'b1, 2'd1, 2'd0, 1'b0);
      tick(); tick();
      chk("blink_attr0", o4, O_BLK);
      pix(1'b1, 1'b1, 2'd1, 2'd0, 1'b1); step2();
      chk("blink_t6", o4, O_BLNK);

      // Mid-frame reset reverts the palette and the blink phase
      wr(2'd0, 24'h010203);
      pix(1'b1, 1'b0, 2'd1, 2'd0, 1'b0); step2();
      chk("pre_rst_entry0", o4, {1'b1, 24'h010203});
      #3 rst_n = 1'b0;
      #1 chk("async_rst_out", o4, O_OFF);
      step();
      rst_n = 1'b1;
      step2();
      chk("post_rst_entry0", o4, O_YEL);
      pix(1'b1, 1'b1, 2'd1, 2'd0, 1'b1); step2();
      chk("post_rst_phase0", o4, O_BLK);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
